// File: rtl/seqdet_sched_if.sv
// Bus bundle between seqdet_sched, its two word requesters, the response consumer
// and the shared serial detector. The slave modport is the scheduler's view.
interface seqdet_sched_if #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_data;
    logic             req1_ready;
    logic             det_clr;
    logic             det_din;
    logic             det_dout;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic             rsp_hit;
    logic [CW-1:0]    rsp_count;

    modport slave (
        input  req0_valid, req0_data,
        output req0_ready,
        input  req1_valid, req1_data,
        output req1_ready,
        output det_clr, det_din,
        input  det_dout,
        output rsp_valid, rsp_id, rsp_hit, rsp_count,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_data,
        input  req0_ready,
        output req1_valid, req1_data,
        input  req1_ready,
        input  det_clr, det_din,
        output det_dout,
        input  rsp_valid, rsp_id, rsp_hit, rsp_count,
        output rsp_ready
    );
endinterface

// File: rtl/seqdet_sched.sv
// Round-robin scheduler sharing one serial Moore sequence detector between two
// word requesters: clear detector, shift word MSB-first, count match pulses, respond.
module seqdet_sched #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          clr_n,
    seqdet_sched_if.slave bus,
    output logic [2:0]    o_dbg_state
);
    // Handshakes: a requester word transfers in the IDLE cycle where its
    // reqN_ready pulses (ready is combinational on valid, so valid may be held
    // or dropped freely afterwards); a response transfers on the cycle where
    // rsp_valid && rsp_ready, and all rsp_* hold while rsp_ready is low.

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_SHIFT = 3'd2,
        S_DRAIN = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t           r_state, w_state_nxt;
    logic             r_rr, w_rr_nxt;
    logic [WIDTH-1:0] r_shift, w_shift_nxt;
    logic [IW-1:0]    r_idx, w_idx_nxt;
    logic [CW-1:0]    r_count, w_count_nxt;
    logic             r_id, w_id_nxt;
    logic             r_det_clr, w_det_clr_nxt;
    logic             r_det_din, w_det_din_nxt;
    logic             w_grant0, w_grant1, w_idle, w_sample;

    // r_rr == 0 favours req0; the favoured requester wins whenever it is valid
    assign w_grant0 = bus.req0_valid && (!r_rr || !bus.req1_valid);
    assign w_grant1 = bus.req1_valid && ( r_rr || !bus.req0_valid);
    assign w_idle   = (r_state == S_IDLE);

    // det_dout lags det_din by one cycle, so bit 0's result appears in shift cycle 1
    assign w_sample = ((r_state == S_SHIFT) && (r_idx != '0)) || (r_state == S_DRAIN);

    always_comb begin
        w_state_nxt   = r_state;
        w_rr_nxt      = r_rr;
        w_shift_nxt   = r_shift;
        w_idx_nxt     = r_idx;
        w_count_nxt   = r_count;
        w_id_nxt      = r_id;
        w_det_clr_nxt = 1'b0;
        w_det_din_nxt = 1'b0;

        if (w_sample && bus.det_dout && (r_count != '1)) begin
            w_count_nxt = r_count + 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (w_grant0 || w_grant1) begin
                    w_state_nxt   = S_CLEAR;
                    w_shift_nxt   = w_grant0 ? bus.req0_data : bus.req1_data;
                    w_id_nxt      = w_grant1;
                    w_rr_nxt      = w_grant0;
                    w_count_nxt   = '0;
                    w_det_clr_nxt = 1'b1;
                end
            end
            S_CLEAR: begin
                w_state_nxt   = S_SHIFT;
                w_idx_nxt     = '0;
                w_count_nxt   = '0;
                w_det_din_nxt = r_shift[WIDTH-1];
                w_shift_nxt   = r_shift << 1;
            end
            S_SHIFT: begin
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_idx_nxt     = r_idx + 1'b1;
                    w_det_din_nxt = r_shift[WIDTH-1];
                    w_shift_nxt   = r_shift << 1;
                end
            end
            S_DRAIN: begin
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state   <= S_IDLE;
            r_rr      <= 1'b0;
            r_shift   <= '0;
            r_idx     <= '0;
            r_count   <= '0;
            r_id      <= 1'b0;
            r_det_clr <= 1'b1;
            r_det_din <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rr      <= w_rr_nxt;
            r_shift   <= w_shift_nxt;
            r_idx     <= w_idx_nxt;
            r_count   <= w_count_nxt;
            r_id      <= w_id_nxt;
            r_det_clr <= w_det_clr_nxt;
            r_det_din <= w_det_din_nxt;
        end
    end

    // ready is gated by clr_n so no accept can be signalled while in reset
    assign bus.req0_ready = clr_n && w_idle && w_grant0;
    assign bus.req1_ready = clr_n && w_idle && w_grant1;

    assign bus.det_clr   = r_det_clr;
    assign bus.det_din   = r_det_din;
    assign bus.rsp_valid = (r_state == S_RESP);
    assign bus.rsp_id    = r_id;
    assign bus.rsp_count = r_count;
    assign bus.rsp_hit   = (r_count != '0);

    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_seqdet_sched.sv
// Directed bench for seqdet_sched with a behavioural 1-0-0-0-1 Moore detector
// and a queue-based response scoreboard.
module tb_seqdet_sched;
    localparam int WIDTH = 8;
    localparam int CW    = 4;
    localparam int W     = CW + 1;

    logic       clk = 1'b0;
    logic       clr_n;
    logic [2:0] dbg_state;
    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    logic [W-1:0] exp_q[$];

    seqdet_sched_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

    seqdet_sched #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Moore 1-0-0-0-1 detector with active-high async clear, overlapping matches
    logic [4:0] det_hist;
    always @(posedge clk or posedge bus.det_clr) begin
        if (bus.det_clr) det_hist <= '0;
        else             det_hist <= {det_hist[3:0], bus.det_din};
    end
    assign bus.det_dout = (det_hist == 5'b10001);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (clr_n === 1'b1 && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rsp_unexpected: got id=%0d count=%0d, expected no response", bus.rsp_id, bus.rsp_count);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                check("rsp_id", bus.rsp_id, e[W-1]);
                check("rsp_count", bus.rsp_count, e[CW-1:0]);
                check("rsp_hit", bus.rsp_hit, e[CW-1:0] != 0);
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic v, input logic [WIDTH-1:0] d);
        if (id == 0) begin
            bus.req0_valid = v;
            bus.req0_data  = d;
        end else begin
            bus.req1_valid = v;
            bus.req1_data  = d;
        end
    endtask

    function automatic logic get_ready(input int id);
        return (id == 0) ? bus.req0_ready : bus.req1_ready;
    endfunction

    task automatic wait_accept(input int id, output bit ok);
        ok = 0;
        for (int t = 0; t < 40 && !ok; t++) begin
            @(negedge clk);
            if (get_ready(id) === 1'b1) ok = 1;
        end
        check("accept_seen", ok, 1);
    endtask

    task automatic wait_q_empty(input int max);
        for (int t = 0; t < max && exp_q.size() != 0; t++) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
    endtask

    // one word with full timing checks; DUT must be idle and rsp_ready high
    task automatic run_word(input int id, input logic [WIDTH-1:0] data, input int exp_cnt);
        bit ok;
        step();
        set_req(id, 1'b1, data);
        wait_accept(id, ok);
        if (!ok) return;
        check("accept_other_ready", get_ready(1 - id), 0);
        check("accept_det_clr", bus.det_clr, 0);
        exp_q.push_back({id[0], CW'(exp_cnt)});
        step();
        set_req(id, 1'b0, ~data);
        @(negedge clk);
        check("clear_det_clr", bus.det_clr, 1);
        check("clear_det_din", bus.det_din, 0);
        for (int i = 0; i < WIDTH; i++) begin
            @(negedge clk);
            check("shift_det_clr", bus.det_clr, 0);
            check("shift_det_din", bus.det_din, data[WIDTH-1-i]);
        end
        @(negedge clk);
        check("drain_det_din", bus.det_din, 0);
        check("drain_rsp_valid", bus.rsp_valid, 0);
        @(negedge clk);
        check("latency_rsp_valid", bus.rsp_valid, 1);
    endtask

    logic [WIDTH-1:0] c0 [2];
    logic [WIDTH-1:0] c1 [2];
    int e0 [2];
    int e1 [2];

    initial begin
        bit ok;
        int got, last, i0, i1;
        clr_n          = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'h88;
        bus.req1_valid = 1'b0;
        bus.req1_data  = '0;
        bus.rsp_ready  = 1'b1;

        // reset then idle
        repeat (3) @(negedge clk);
        check("rst_det_clr", bus.det_clr, 1);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_req0_ready", bus.req0_ready, 0);
        check("rst_req1_ready", bus.req1_ready, 0);
        check("rst_rsp_count", bus.rsp_count, 0);
        check("rst_rsp_id", bus.rsp_id, 0);
        check("rst_det_din", bus.det_din, 0);
        step();
        bus.req0_valid = 1'b0;
        clr_n = 1'b1;
        @(negedge clk);
        check("idle_det_clr_pre", bus.det_clr, 1);
        @(negedge clk);
        check("idle_det_clr", bus.det_clr, 0);
        check("idle_state", dbg_state, 0);
        @(negedge clk);
        check("idle_stays", dbg_state, 0);

        // single words (hand-computed match counts for 1-0-0-0-1)
        run_word(0, 8'b1000_1000, 1);
        run_word(1, 8'hFF, 0);
        run_word(0, 8'h11, 1);
        run_word(1, 8'hAA, 0);
        run_word(0, 8'h44, 1);
        run_word(1, 8'h00, 0);
        wait_q_empty(20);

        // contention: both valid, grants alternate starting with req0
        c0[0] = 8'h88; e0[0] = 1;  c0[1] = 8'hF1; e0[1] = 1;
        c1[0] = 8'h0F; e1[0] = 0;  c1[1] = 8'h11; e1[1] = 1;
        i0 = 0; i1 = 0; last = 0;
        step();
        set_req(0, 1'b1, c0[0]);
        set_req(1, 1'b1, c1[0]);
        for (int k = 0; k < 4; k++) begin
            ok = 0;
            for (int t = 0; t < 30 && !ok; t++) begin
                @(negedge clk);
                if (bus.req0_ready === 1'b1 || bus.req1_ready === 1'b1) ok = 1;
            end
            check("cont_accept", ok, 1);
            if (!ok) break;
            check("cont_one_hot", bus.req0_ready && bus.req1_ready, 0);
            got = bus.req1_ready ? 1 : 0;
            check("cont_order", got, k % 2);
            if (k > 0) check("cont_period", cyc - last, 12);
            last = cyc;
            if (got == 0) exp_q.push_back({1'b0, CW'(e0[i0])});
            else          exp_q.push_back({1'b1, CW'(e1[i1])});
            step();
            if (got == 0) begin
                i0++;
                if (i0 < 2) set_req(0, 1'b1, c0[i0]); else set_req(0, 1'b0, '0);
            end else begin
                i1++;
                if (i1 < 2) set_req(1, 1'b1, c1[i1]); else set_req(1, 1'b0, '0);
            end
        end
        set_req(0, 1'b0, '0);
        set_req(1, 1'b0, '0);
        wait_q_empty(40);

        // backpressure
        step();
        bus.rsp_ready = 1'b0;
        set_req(0, 1'b1, 8'h44);
        wait_accept(0, ok);
        exp_q.push_back({1'b0, CW'(1)});
        step();
        set_req(0, 1'b0, '0);
        ok = 0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) ok = 1;
        end
        check("bp_rsp_valid_seen", ok, 1);
        set_req(0, 1'b1, 8'h88);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", bus.rsp_valid, 1);
            check("bp_hold_id", bus.rsp_id, 0);
            check("bp_hold_count", bus.rsp_count, 1);
            check("bp_hold_hit", bus.rsp_hit, 1);
            check("bp_no_accept", bus.req0_ready, 0);
            @(negedge clk);
        end
        step();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", bus.rsp_valid, 1);
        check("bp_release_no_accept", bus.req0_ready, 0);
        @(negedge clk);
        check("bp_next_accept", bus.req0_ready, 1);
        exp_q.push_back({1'b0, CW'(1)});
        step();
        set_req(0, 1'b0, '0);
        wait_q_empty(30);

        // mid-word reset: word dropped, pointer back to req0
        step();
        set_req(0, 1'b1, 8'h88);
        wait_accept(0, ok);
        step();
        set_req(0, 1'b0, '0);
        repeat (4) step();
        clr_n = 1'b0;
        #1;
        check("mrst_det_clr", bus.det_clr, 1);
        check("mrst_det_din", bus.det_din, 0);
        check("mrst_rsp_valid", bus.rsp_valid, 0);
        check("mrst_rsp_count", bus.rsp_count, 0);
        check("mrst_state", dbg_state, 0);
        repeat (2) step();
        clr_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("mrst_no_rsp", bus.rsp_valid, 0);
        end
        step();
        set_req(0, 1'b1, 8'h11);
        set_req(1, 1'b1, 8'hAA);
        @(negedge clk);
        check("mrst_grant_req0", bus.req0_ready, 1);
        check("mrst_not_req1", bus.req1_ready, 0);
        exp_q.push_back({1'b0, CW'(1)});
        step();
        set_req(0, 1'b0, '0);
        set_req(1, 1'b0, '0);
        wait_q_empty(30);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/seqdet_sched.md
Name: seqdet_sched

Overview:
- Controller that shares one serial Moore sequence detector (din/dout, active-high async clear) between two word-level requesters.
- Arbitrates round-robin and captures one WIDTH-bit word per grant.
- Clears the detector, then shifts the word into it MSB-first and counts the detector's match pulses.
- Returns a per-word response tagged with the requester id. Sits between the requesters and the single detector instance.

Parameters:
- WIDTH, 8, bits per word shifted into the detector.
- CW, 4, hit-counter width; requirement 2**CW > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- clr_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has a word.
- req0_data  input  WIDTH  requester 0 word.
- req0_ready  output  1  one-cycle accept pulse for requester 0.
- req1_valid  input  1  requester 1 has a word.
- req1_data  input  WIDTH  requester 1 word.
- req1_ready  output  1  one-cycle accept pulse for requester 1.
- det_clr  output  1  clear to detector, active high, registered.
- det_din  output  1  serial bit to detector, registered.
- det_dout  input  1  detector Moore output.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  response consumer accepts.
- rsp_id  output  1  requester that owned the word.
- rsp_hit  output  1  rsp_count != 0.
- rsp_count  output  CW  number of det_dout highs sampled for the word.

Behaviour:
- Reset (clr_n low, async): state IDLE, rr pointer favours req0, shift/count regs 0, req*_ready=0, rsp_valid=0, rsp_id=0, rsp_count=0, det_din=0, det_clr=1. Detector is held clear while in reset.
- States and timing, with the accept cycle as T:
  - IDLE: det_clr=0. If any valid, grant per rr pointer (the favoured requester wins if valid, otherwise the other). Pulse its ready in this same cycle T, capture data and id, flip the pointer to favour the non-granted requester, go to CLEAR. If no valid, stay.
  - CLEAR (T+1): det_clr=1, det_din=0, count cleared.
  - SHIFT (T+2 .. T+1+WIDTH): det_clr=0; det_din = word[WIDTH-1-i] in shift cycle i. From shift cycle 1 on, det_dout is sampled each cycle; each high sample adds 1 to count.
  - DRAIN (T+WIDTH+2): det_din=0; det_dout sampled once more for the last bit.
  - RESP (from T+WIDTH+3): rsp_valid=1 with id/hit/count stable. Leave to IDLE on the cycle rsp_valid && rsp_ready. No new grant occurs while in RESP.
- det_dout is ignored in IDLE, CLEAR, shift cycle 0 and RESP.
- Latency from accept to rsp_valid: WIDTH+3 cycles (11 for WIDTH=8).
- Throughput: one word per WIDTH+4 cycles when rsp_ready is tied high.
- Both valids in the same IDLE cycle: the favoured one wins; the loser is granted next, with no starvation.
- req*_ready is only ever asserted in IDLE and is never high for both requesters at once.
- req*_data is sampled only in the accept cycle; later changes are ignored.
- Count saturates at 2**CW-1 (unreachable when CW is legal; still required).
- clr_n asserted mid-word: word is dropped, no response, return to reset values immediately.
- rsp_valid held low by rsp_ready=0: all rsp_* hold, no new accept.

Test Plan:
- Reset then idle: clr_n low 3 cycles → det_clr=1, rsp_valid=0, both readies 0. Release with no valids → det_clr=0 next cycle, stays IDLE.
- Single word: req0 sends 8'b1000_1000 on the team's 1-0-0-0-1 detector → req0_ready at T; det_din sequence 1,0,0,0,1,0,0,0 over T+2..T+9; rsp_valid at T+11 with rsp_id=0, rsp_count=1, rsp_hit=1.
- No match: req1 sends 8'hFF → rsp_id=1, rsp_count=0, rsp_hit=0. det_clr high exactly one cycle, at T+1.
- Contention: both valid continuously with distinct words, rsp_ready=1 → grants alternate 0,1,0,1, one accept every 12 cycles. Responses are in grant order with correct ids.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid → outputs stable, req0_valid ignored. Raise rsp_ready → back to IDLE, next accept the following cycle.
- Mid-word reset: drop clr_n at T+5 → det_clr=1 and outputs at reset values immediately. No response appears after release; the next grant goes to req0.
